// File: rtl/gcd_job_sequencer.sv
// rtl/gcd_job_sequencer.sv - job front-end that clears, loads and waits on a subtractive GCD core
// Zero operands bypass the core; a WAIT-cycle timeout aborts a hung job with an error flag.
module gcd_job_sequencer #(
    parameter int W              = 16,
    parameter int TIMEOUT_CYCLES = 65544,
    parameter int CNT_W          = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_gcd,
    output logic         out_err,
    output logic         busy,
    output logic         gcd_clr,
    output logic         gcd_start,
    output logic [W-1:0] gcd_data_in,
    input  logic         gcd_done,
    input  logic [W-1:0] gcd_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_gcd;
    logic           r_err;
    logic [CNT_W-1:0] r_cnt;

    logic w_accept;
    logic w_zero;
    logic w_timeout;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_zero    = (in_a == '0) || (in_b == '0);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_next = w_zero ? S_RESULT : S_CLEAR;
            S_CLEAR:  w_next = S_LOAD_A;
            S_LOAD_A: w_next = S_LOAD_B;
            S_LOAD_B: w_next = S_WAIT;
            S_WAIT:   if (gcd_done || w_timeout) w_next = S_RESULT;
            S_RESULT: if (out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_gcd   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a <= in_a;
                r_b <= in_b;
                if (w_zero) begin
                    r_gcd <= in_a | in_b;
                    r_err <= 1'b0;
                end
            end
            if (r_state == S_LOAD_B) begin
                r_cnt <= '0;
            end
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
                // done takes priority over a coincident timeout
                if (gcd_done) begin
                    r_gcd <= gcd_result;
                    r_err <= 1'b0;
                end else if (w_timeout) begin
                    r_gcd <= '0;
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign out_valid   = (r_state == S_RESULT);
    assign out_gcd     = r_gcd;
    assign out_err     = r_err;
    assign gcd_clr     = (r_state == S_CLEAR);
    assign gcd_start   = (r_state == S_LOAD_A);
    assign gcd_data_in = ((r_state == S_CLEAR) || (r_state == S_LOAD_A)) ? r_a :
                         ((r_state == S_LOAD_B) || (r_state == S_WAIT))  ? r_b : '0;

endmodule
